// File: rtl/counter_sequencer_if.sv
// Command handshake between a requester and the counter sequencer.
interface counter_sequencer_if #(
    parameter int WIDTH = 8
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [0:1]       cmd_op;
    logic [0:WIDTH-1] cmd_data;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_data,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_data,
        output cmd_ready
    );
endinterface

// File: rtl/counter_sequencer.sv
// Command-driven controller for a free-running 8-bit up/down counter:
// holds it by reloading, runs it to a target, and reports completion.
module counter_sequencer #(
    parameter  int WIDTH     = 8,
    parameter  int MAX_STEPS = 256,
    localparam int STEP_W    = $clog2(MAX_STEPS + 1)
) (
    input  logic                clk,
    input  logic                clr,
    counter_sequencer_if.slave  cmd,
    input  logic                abort,
    input  logic [0:WIDTH-1]    count_fb,
    output logic                ctr_mode,
    output logic                ctr_ld,
    output logic [0:WIDTH-1]    ctr_d_in,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [0:STEP_W-1]   steps
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_RUN
    } state_t;

    typedef enum logic [1:0] {
        OP_LOAD  = 2'b00,
        OP_UP    = 2'b01,
        OP_DOWN  = 2'b10,
        OP_CLEAR = 2'b11
    } op_t;

    state_t           r_state;
    logic [0:WIDTH-1] r_hold;
    logic [0:WIDTH-1] r_target;
    logic             r_dir;
    logic [0:STEP_W-1] r_steps;
    logic             r_done;
    logic             r_err;

    state_t           w_state_nxt;
    logic [0:WIDTH-1] w_hold_nxt;
    logic [0:WIDTH-1] w_target_nxt;
    logic             w_dir_nxt;
    logic [0:STEP_W-1] w_steps_nxt;
    logic             w_done_nxt;
    logic             w_err_nxt;
    logic             w_match;
    logic             w_limit;
    op_t              w_op;

    assign w_match = (count_fb == r_target);
    assign w_limit = (r_steps == STEP_W'(MAX_STEPS));
    assign w_op    = op_t'(cmd.cmd_op);

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_state  <= S_IDLE;
            r_hold   <= '0;
            r_target <= '0;
            r_dir    <= 1'b0;
            r_steps  <= '0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_hold   <= w_hold_nxt;
            r_target <= w_target_nxt;
            r_dir    <= w_dir_nxt;
            r_steps  <= w_steps_nxt;
            r_done   <= w_done_nxt;
            r_err    <= w_err_nxt;
        end
    end

    // The counter has no enable, so every non-running state keeps ctr_ld high.
    always_comb begin
        w_state_nxt   = r_state;
        w_hold_nxt    = r_hold;
        w_target_nxt  = r_target;
        w_dir_nxt     = r_dir;
        w_steps_nxt   = r_steps;
        w_done_nxt    = 1'b0;
        w_err_nxt     = r_err;
        ctr_ld        = 1'b1;
        ctr_d_in      = r_hold;
        ctr_mode      = 1'b0;
        cmd.cmd_ready = 1'b0;

        case (r_state)
            S_IDLE: begin
                cmd.cmd_ready = clr;
                if (cmd.cmd_valid && clr) begin
                    w_err_nxt = 1'b0;
                    case (w_op)
                        OP_LOAD: begin
                            w_hold_nxt  = cmd.cmd_data;
                            w_state_nxt = S_SETTLE;
                        end
                        OP_CLEAR: begin
                            w_hold_nxt  = '0;
                            w_state_nxt = S_SETTLE;
                        end
                        default: begin
                            w_target_nxt = cmd.cmd_data;
                            w_dir_nxt    = (w_op == OP_UP);
                            w_steps_nxt  = '0;
                            w_state_nxt  = S_RUN;
                        end
                    endcase
                end
            end

            S_SETTLE: begin
                w_state_nxt = S_IDLE;
                w_done_nxt  = 1'b1;
            end

            S_RUN: begin
                ctr_mode = r_dir;
                ctr_d_in = r_target;
                ctr_ld   = w_match;
                if (w_match) begin
                    w_hold_nxt  = r_target;
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = 1'b1;
                end else if (abort || w_limit) begin
                    // Freeze on the value the counter shows right now.
                    ctr_ld      = 1'b1;
                    ctr_d_in    = count_fb;
                    w_hold_nxt  = count_fb;
                    w_state_nxt = S_IDLE;
                    if (!abort) begin
                        w_err_nxt = 1'b1;
                    end
                end else begin
                    w_steps_nxt = r_steps + 1'b1;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign busy  = (r_state != S_IDLE);
    assign done  = r_done;
    assign err   = r_err;
    assign steps = r_steps;

endmodule

// File: tb/tb_counter_sequencer.sv
// Scoreboard bench: a behavioural counter closes the loop around the sequencer.
module tb_counter_sequencer;

    localparam int W  = 8;
    localparam int MS = 256;
    localparam int SW = 9;

    logic          clk   = 1'b0;
    logic          clr   = 1'b0;
    logic          abort = 1'b0;
    logic          stuck = 1'b0;
    logic [0:W-1]  r_cnt;
    logic [0:W-1]  count_fb;
    logic          ctr_mode;
    logic          ctr_ld;
    logic [0:W-1]  ctr_d_in;
    logic          busy;
    logic          done;
    logic          err;
    logic [0:SW-1] steps;

    counter_sequencer_if #(.WIDTH(W)) cmd_bus ();

    counter_sequencer #(
        .WIDTH     (W),
        .MAX_STEPS (MS)
    ) dut (
        .clk      (clk),
        .clr      (clr),
        .cmd      (cmd_bus),
        .abort    (abort),
        .count_fb (count_fb),
        .ctr_mode (ctr_mode),
        .ctr_ld   (ctr_ld),
        .ctr_d_in (ctr_d_in),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .steps    (steps)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ctr_ld)        r_cnt <= ctr_d_in;
        else if (ctr_mode) r_cnt <= r_cnt + 8'd1;
        else               r_cnt <= r_cnt - 8'd1;
    end

    assign count_fb = stuck ? 8'h10 : r_cnt;

    typedef struct packed {
        logic [7:0] cnt;
        logic [8:0] stp;
        logic       chk_stp;
    } exp_t;

    exp_t q[$];
    exp_t m_e;
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (clr && done) begin
            if (q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_done: done=1 expected 0 at %0t", $time);
            end else begin
                m_e = q.pop_front();
                check("done_count", 32'(count_fb), 32'(m_e.cnt));
                if (m_e.chk_stp) check("done_steps", 32'(steps), 32'(m_e.stp));
                check("done_err", 32'(err), 32'd0);
            end
        end
    end

    task automatic issue(input logic [1:0] op, input logic [7:0] data);
        bit ok;
        ok = 1'b0;
        @(posedge clk);
        #1;
        cmd_bus.cmd_valid = 1'b1;
        cmd_bus.cmd_op    = op;
        cmd_bus.cmd_data  = data;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (cmd_bus.cmd_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_tests++;
            n_fail++;
            $display("FAIL accept_timeout: cmd_ready=0 expected 1");
        end
        @(posedge clk);
        #1;
        cmd_bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            n++;
            if (!busy) break;
        end
        if (busy) begin
            n_tests++;
            n_fail++;
            $display("FAIL idle_timeout: busy=1 expected 0");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int          n;
        bit          found;
        logic [7:0]  dn_seq [5];
        dn_seq = '{8'h02, 8'h01, 8'h00, 8'hFF, 8'hFE};

        cmd_bus.cmd_valid = 1'b0;
        cmd_bus.cmd_op    = 2'b00;
        cmd_bus.cmd_data  = 8'h00;

        repeat (3) @(negedge clk);
        check("rst_ld",    32'(ctr_ld), 32'd1);
        check("rst_din",   32'(ctr_d_in), 32'd0);
        check("rst_mode",  32'(ctr_mode), 32'd0);
        check("rst_ready", 32'(cmd_bus.cmd_ready), 32'd0);
        @(posedge clk);
        #1 clr = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_count", 32'(count_fb), 32'h00);
        check("idle_ld",    32'(ctr_ld), 32'd1);
        check("idle_busy",  32'(busy), 32'd0);
        check("idle_ready", 32'(cmd_bus.cmd_ready), 32'd1);
        check("idle_err",   32'(err), 32'd0);
        check("idle_done",  32'(done), 32'd0);
        check("idle_steps", 32'(steps), 32'd0);

        q.push_back(exp_t'{8'h5A, 9'd0, 1'b0});
        issue(2'b00, 8'h5A);
        wait_idle(n);
        check("load_latency", n, 32'd2);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("load_hold", 32'(count_fb), 32'h5A);
        end

        q.push_back(exp_t'{8'h05, 9'd0, 1'b0});
        issue(2'b00, 8'h05);
        wait_idle(n);
        q.push_back(exp_t'{8'h08, 9'd3, 1'b1});
        issue(2'b01, 8'h08);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("up_seq", 32'(count_fb), 32'(8'h05 + i));
        end
        wait_idle(n);
        check("up_done_delay", n, 32'd1);
        repeat (2) @(negedge clk);
        check("up_hold", 32'(count_fb), 32'h08);

        q.push_back(exp_t'{8'h02, 9'd0, 1'b0});
        issue(2'b00, 8'h02);
        wait_idle(n);
        q.push_back(exp_t'{8'hFE, 9'd4, 1'b1});
        issue(2'b10, 8'hFE);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("down_seq", 32'(count_fb), 32'(dn_seq[i]));
        end
        wait_idle(n);
        check("down_done_delay", n, 32'd1);
        check("down_err", 32'(err), 32'd0);

        q.push_back(exp_t'{8'h00, 9'd0, 1'b0});
        issue(2'b11, 8'hA5);
        wait_idle(n);
        issue(2'b01, 8'hC8);
        found = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (count_fb == 8'h10) begin
                abort = 1'b1;
                found = 1'b1;
                break;
            end
        end
        check("abort_reached", 32'(found), 32'd1);
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        check("abort_busy",  32'(busy), 32'd0);
        check("abort_count", 32'(count_fb), 32'h10);
        check("abort_err",   32'(err), 32'd0);
        check("abort_steps", 32'(steps), 32'd16);
        repeat (3) @(negedge clk);
        check("abort_hold", 32'(count_fb), 32'h10);
        q.push_back(exp_t'{8'h00, 9'd0, 1'b0});
        issue(2'b11, 8'h00);
        wait_idle(n);
        check("clear_count", 32'(count_fb), 32'h00);

        q.push_back(exp_t'{8'h33, 9'd0, 1'b0});
        issue(2'b00, 8'h33);
        wait_idle(n);
        q.push_back(exp_t'{8'h33, 9'd0, 1'b1});
        issue(2'b01, 8'h33);
        wait_idle(n);
        check("zero_len_latency", n, 32'd2);

        @(posedge clk);
        #1 stuck = 1'b1;
        issue(2'b01, 8'h20);
        wait_idle(n);
        check("wd_latency", n, 32'd258);
        check("wd_err",   32'(err), 32'd1);
        check("wd_busy",  32'(busy), 32'd0);
        check("wd_steps", 32'(steps), 32'd256);
        @(posedge clk);
        #1 stuck = 1'b0;
        @(negedge clk);
        check("wd_frozen", 32'(count_fb), 32'h10);
        q.push_back(exp_t'{8'h44, 9'd0, 1'b0});
        issue(2'b00, 8'h44);
        check("wd_err_clear", 32'(err), 32'd0);
        wait_idle(n);

        issue(2'b01, 8'h40);
        repeat (5) @(negedge clk);
        check("midrun_busy", 32'(busy), 32'd1);
        clr = 1'b0;
        #1;
        check("midrun_rst_busy",  32'(busy), 32'd0);
        check("midrun_rst_steps", 32'(steps), 32'd0);
        check("midrun_rst_ld",    32'(ctr_ld), 32'd1);
        check("midrun_rst_din",   32'(ctr_d_in), 32'd0);
        check("midrun_rst_ready", 32'(cmd_bus.cmd_ready), 32'd0);
        @(posedge clk);
        #1 clr = 1'b1;
        repeat (2) @(negedge clk);
        check("midrun_rst_count", 32'(count_fb), 32'h00);

        repeat (3) @(negedge clk);
        check("pending_done", q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
